// File: rtl/eth_mac_stats_pkg.sv
// Shared constants for the MAC/FIFO statistics counter bank: channel map and default sizing.
package eth_mac_stats_pkg;
  localparam int CH_TX_UNDERFLOW = 0;
  localparam int CH_TX_FIFO_OVF  = 1;
  localparam int CH_TX_FIFO_BAD  = 2;
  localparam int CH_TX_FIFO_GOOD = 3;
  localparam int CH_RX_BAD_FRAME = 4;
  localparam int CH_RX_BAD_FCS   = 5;
  localparam int CH_RX_FIFO_OVF  = 6;
  localparam int CH_RX_FIFO_BAD  = 7;
  localparam int CH_RX_FIFO_GOOD = 8;
  localparam int CH_SPEED_CHG    = 9;

  localparam int DEF_N_CH  = 10;
  localparam int DEF_CNT_W = 32;

  // Read address width; never narrower than one bit so a single-channel bank still has a port.
  function automatic int addr_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/eth_mac_stats_if.sv
// Event/snapshot/read bus of the statistics bank. ETH_MAC_STATS_IRQ_EN adds the threshold-irq config.
interface eth_mac_stats_if import eth_mac_stats_pkg::*; #(
  parameter int N_CH   = DEF_N_CH,
  parameter int CNT_W  = DEF_CNT_W,
  parameter int ADDR_W = addr_w(N_CH)
) ();
  logic [N_CH-1:0]   evt_in;
  logic              snap_req;
  logic              snap_clear;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              rd_err;
  logic [N_CH-1:0]   ovf;
  logic              irq;
`ifdef ETH_MAC_STATS_IRQ_EN
  logic [CNT_W-1:0]  cfg_irq_thresh;
  logic [N_CH-1:0]   cfg_irq_mask;

  modport master (output evt_in, snap_req, snap_clear, rd_en, rd_addr, cfg_irq_thresh, cfg_irq_mask,
                  input  rd_data, rd_valid, rd_err, ovf, irq);
  modport slave  (input  evt_in, snap_req, snap_clear, rd_en, rd_addr, cfg_irq_thresh, cfg_irq_mask,
                  output rd_data, rd_valid, rd_err, ovf, irq);
`else
  modport master (output evt_in, snap_req, snap_clear, rd_en, rd_addr,
                  input  rd_data, rd_valid, rd_err, ovf, irq);
  modport slave  (input  evt_in, snap_req, snap_clear, rd_en, rd_addr,
                  output rd_data, rd_valid, rd_err, ovf, irq);
`endif
endinterface

// File: rtl/eth_mac_stats_cnt.sv
// One statistics channel: live counter with wrap/saturate, sticky overflow flag and snapshot shadow.
module eth_mac_stats_cnt #(
  parameter int CNT_W    = 32,
  parameter int SATURATE = 1
) (
  input  logic             logic_clk,
  input  logic             logic_rst,
  input  logic             evt,
  input  logic             snap,
  input  logic             clr,
  output logic [CNT_W-1:0] live,
  output logic [CNT_W-1:0] shadow,
  output logic             ovf
);
  logic             at_max;
  logic             wrap_evt;
  logic [CNT_W-1:0] live_nxt;

  assign at_max   = &live;
  assign wrap_evt = evt & at_max;

  always_comb begin
    live_nxt = live;
    if (evt) begin
      if (at_max) live_nxt = (SATURATE != 0) ? live : '0;
      else        live_nxt = live + CNT_W'(1);
    end
  end

  // A clearing snapshot restarts the period with this cycle's event so no pulse is lost.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      live   <= '0;
      shadow <= '0;
      ovf    <= 1'b0;
    end else begin
      if (clr) begin
        live <= CNT_W'(evt);
        ovf  <= wrap_evt;
      end else begin
        live <= live_nxt;
        ovf  <= ovf | wrap_evt;
      end
      if (snap) shadow <= live;
    end
  end
endmodule

// File: rtl/eth_mac_stats.sv
// Statistics counter bank: N_CH channels, atomic snapshot, registered shadow read port.
// Optional ETH_MAC_STATS_IRQ_EN adds a masked threshold/overflow interrupt (mask bit 1 = channel enabled).
module eth_mac_stats import eth_mac_stats_pkg::*; #(
  parameter int N_CH     = DEF_N_CH,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = 1,
  parameter int ADDR_W   = addr_w(N_CH)
) (
  input  logic             logic_clk,
  input  logic             logic_rst,
  eth_mac_stats_if.slave   bus
);
  logic [N_CH-1:0][CNT_W-1:0] live;
  logic [N_CH-1:0][CNT_W-1:0] shadow;
  logic [N_CH-1:0]            ovf_q;
  logic                       snap_clr;
  logic                       addr_oob;
  logic [CNT_W-1:0]           rd_data_q;
  logic                       rd_valid_q;
  logic                       rd_err_q;

  assign snap_clr = bus.snap_req & bus.snap_clear;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    eth_mac_stats_cnt #(.CNT_W(CNT_W), .SATURATE(SATURATE)) u_cnt (
      .logic_clk (logic_clk),
      .logic_rst (logic_rst),
      .evt       (bus.evt_in[i]),
      .snap      (bus.snap_req),
      .clr       (snap_clr),
      .live      (live[i]),
      .shadow    (shadow[i]),
      .ovf       (ovf_q[i])
    );
  end

  assign addr_oob = ({1'b0, bus.rd_addr} >= (ADDR_W+1)'(N_CH));

  // Shadow is read before this edge's snapshot lands, so a same-cycle read sees the old period.
  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= bus.rd_en;
      if (bus.rd_en) begin
        rd_err_q  <= addr_oob;
        rd_data_q <= addr_oob ? '0 : shadow[bus.rd_addr];
      end
    end
  end

  assign bus.rd_data  = rd_data_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.ovf      = ovf_q;

`ifdef ETH_MAC_STATS_IRQ_EN
  logic [N_CH-1:0] hit;
  logic            irq_q;

  always_comb begin
    hit = '0;
    for (int i = 0; i < N_CH; i++)
      hit[i] = bus.cfg_irq_mask[i] &
               (((bus.cfg_irq_thresh != '0) && (live[i] >= bus.cfg_irq_thresh)) | ovf_q[i]);
  end

  always_ff @(posedge logic_clk or posedge logic_rst) begin
    if (logic_rst)     irq_q <= 1'b0;
    else if (snap_clr) irq_q <= 1'b0;
    else               irq_q <= irq_q | (|hit);
  end

  assign bus.irq = irq_q;
`else
  logic unused_live;
  assign unused_live = ^live;
  assign bus.irq     = 1'b0;
`endif
endmodule

// File: tb/tb_eth_mac_stats.sv
// Scoreboard bench: saturating and wrapping 8-bit banks driven identically, reads checked by monitors.
module tb_eth_mac_stats;
  import eth_mac_stats_pkg::*;

  localparam int N  = 10;
  localparam int W  = 8;
  localparam int AW = 4;

  typedef struct packed {
    logic [W-1:0] data;
    logic         err;
  } rsp_t;

  logic logic_clk = 1'b0;
  logic logic_rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  rsp_t q_s[$];
  rsp_t q_w[$];
  rsp_t e_s, e_w;
  logic rd_en_d;

  always #5 logic_clk = ~logic_clk;

  eth_mac_stats_if #(.N_CH(N), .CNT_W(W), .ADDR_W(AW)) ifs ();
  eth_mac_stats_if #(.N_CH(N), .CNT_W(W), .ADDR_W(AW)) ifw ();

  eth_mac_stats #(.N_CH(N), .CNT_W(W), .SATURATE(1), .ADDR_W(AW)) u_sat (
    .logic_clk (logic_clk), .logic_rst (logic_rst), .bus (ifs.slave));
  eth_mac_stats #(.N_CH(N), .CNT_W(W), .SATURATE(0), .ADDR_W(AW)) u_wrap (
    .logic_clk (logic_clk), .logic_rst (logic_rst), .bus (ifw.slave));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sync();
    @(posedge logic_clk);
    #1;
  endtask

  task automatic step(input logic [N-1:0] evt, input logic snap, input logic clr,
                      input logic rden, input logic [AW-1:0] addr);
    ifs.evt_in = evt;  ifw.evt_in = evt;
    ifs.snap_req = snap;  ifw.snap_req = snap;
    ifs.snap_clear = clr; ifw.snap_clear = clr;
    ifs.rd_en = rden;  ifw.rd_en = rden;
    ifs.rd_addr = addr; ifw.rd_addr = addr;
    sync();
  endtask

  task automatic idle(input int n);
    repeat (n) step('0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic rd(input int a, input logic [W-1:0] es, input logic [W-1:0] ew,
                    input logic err, input logic snap);
    q_s.push_back('{data: es, err: err});
    q_w.push_back('{data: ew, err: err});
    step('0, snap, 1'b0, 1'b1, AW'(a));
  endtask

  // Expected rd_valid is the bench's own one-cycle delay of rd_en.
  always @(posedge logic_clk or posedge logic_rst)
    if (logic_rst) rd_en_d <= 1'b0;
    else           rd_en_d <= ifs.rd_en;

  always @(negedge logic_clk) begin
    if (!logic_rst) begin
      if (rd_en_d || ifs.rd_valid) chk("rd_valid_sat", 64'(ifs.rd_valid), 64'(rd_en_d));
      if (rd_en_d || ifw.rd_valid) chk("rd_valid_wrap", 64'(ifw.rd_valid), 64'(rd_en_d));
      if (ifs.rd_valid) begin
        if (q_s.size() == 0) chk("unexpected_rd_sat", 64'(q_s.size()), 64'd1);
        else begin
          e_s = q_s.pop_front();
          chk("rd_data_sat", 64'(ifs.rd_data), 64'(e_s.data));
          chk("rd_err_sat", 64'(ifs.rd_err), 64'(e_s.err));
        end
      end
      if (ifw.rd_valid) begin
        if (q_w.size() == 0) chk("unexpected_rd_wrap", 64'(q_w.size()), 64'd1);
        else begin
          e_w = q_w.pop_front();
          chk("rd_data_wrap", 64'(ifw.rd_data), 64'(e_w.data));
          chk("rd_err_wrap", 64'(ifw.rd_err), 64'(e_w.err));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ifs.evt_in = '0; ifs.snap_req = 0; ifs.snap_clear = 0; ifs.rd_en = 0; ifs.rd_addr = '0;
    ifw.evt_in = '0; ifw.snap_req = 0; ifw.snap_clear = 0; ifw.rd_en = 0; ifw.rd_addr = '0;
`ifdef ETH_MAC_STATS_IRQ_EN
    ifs.cfg_irq_thresh = '0; ifs.cfg_irq_mask = '0;
    ifw.cfg_irq_thresh = '0; ifw.cfg_irq_mask = '0;
`endif
    repeat (3) @(posedge logic_clk);
    #1;
    chk("rst_ovf_sat", 64'(ifs.ovf), 64'd0);
    chk("rst_rd_valid", 64'(ifs.rd_valid), 64'd0);
    chk("rst_rd_data", 64'(ifw.rd_data), 64'd0);
    chk("rst_irq", 64'(ifs.irq), 64'd0);
    logic_rst = 1'b0;
    idle(2);

    // Empty bank: snapshot then read every channel back-to-back.
    step('0, 1'b1, 1'b0, 1'b0, '0);
    for (int a = 0; a < N; a++) rd(a, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(2);
    chk("t1_ovf", 64'(ifs.ovf | ifw.ovf), 64'd0);

    // ch3 x5, ch5 x2 (overlapping).
    for (int c = 0; c < 5; c++)
      step(N'(1 << CH_TX_FIFO_GOOD) | ((c < 2) ? N'(1 << CH_RX_BAD_FCS) : N'(0)), 1'b0, 1'b0, 1'b0, '0);
    step('0, 1'b1, 1'b0, 1'b0, '0);
    for (int a = 0; a < N; a++) begin
      if (a == 3)      rd(a, 8'd5, 8'd5, 1'b0, 1'b0);
      else if (a == 5) rd(a, 8'd2, 8'd2, 1'b0, 1'b0);
      else             rd(a, 8'd0, 8'd0, 1'b0, 1'b0);
    end
    step('0, 1'b1, 1'b1, 1'b0, '0);
    idle(2);

    // 300 pulses on ch0: 255 sticky vs 300 mod 256 = 44.
    repeat (300) step(N'(1), 1'b0, 1'b0, 1'b0, '0);
    chk("t3_ovf_sat", 64'(ifs.ovf), 64'h001);
    chk("t3_ovf_wrap", 64'(ifw.ovf), 64'h001);
    step('0, 1'b1, 1'b0, 1'b0, '0);
    rd(0, 8'd255, 8'd44, 1'b0, 1'b0);
    rd(1, 8'd0, 8'd0, 1'b0, 1'b0);

    // live1=7, event in the clearing snapshot cycle starts the new period at 1.
    repeat (7) step(N'(1 << CH_TX_FIFO_OVF), 1'b0, 1'b0, 1'b0, '0);
    step(N'(1 << CH_TX_FIFO_OVF), 1'b1, 1'b1, 1'b0, '0);
    chk("t4_ovf_clr_sat", 64'(ifs.ovf), 64'd0);
    chk("t4_ovf_clr_wrap", 64'(ifw.ovf), 64'd0);
    rd(1, 8'd7, 8'd7, 1'b0, 1'b0);
    rd(0, 8'd255, 8'd44, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0);
    rd(1, 8'd1, 8'd1, 1'b0, 1'b0);
    rd(0, 8'd0, 8'd0, 1'b0, 1'b0);

    // Out-of-range reads, read colliding with snapshot, then reset mid-count.
    rd(N, 8'd0, 8'd0, 1'b1, 1'b0);
    rd(15, 8'd0, 8'd0, 1'b1, 1'b0);
    repeat (3) step(N'(1 << CH_TX_FIFO_BAD), 1'b0, 1'b0, 1'b0, '0);
    rd(2, 8'd0, 8'd0, 1'b0, 1'b1);
    rd(2, 8'd3, 8'd3, 1'b0, 1'b0);
    repeat (4) step('1, 1'b0, 1'b0, 1'b0, '0);
    logic_rst = 1'b1;
    sync();
    step('0, 1'b0, 1'b0, 1'b0, '0);
    chk("t5_rst_ovf", 64'(ifs.ovf | ifw.ovf), 64'd0);
    logic_rst = 1'b0;
    idle(1);
    rd(2, 8'd0, 8'd0, 1'b0, 1'b0);
    step('0, 1'b1, 1'b0, 1'b0, '0);
    for (int a = 0; a < N; a++) rd(a, 8'd0, 8'd0, 1'b0, 1'b0);
    idle(2);

`ifdef ETH_MAC_STATS_IRQ_EN
    ifs.cfg_irq_thresh = 8'd4; ifs.cfg_irq_mask = N'(1 << CH_TX_FIFO_BAD);
    ifw.cfg_irq_thresh = 8'd4; ifw.cfg_irq_mask = N'(1 << CH_TX_FIFO_BAD);
    repeat (5) step(N'(1 << CH_RX_FIFO_OVF), 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    chk("t6_masked_irq", 64'(ifs.irq), 64'd0);
    repeat (3) step(N'(1 << CH_TX_FIFO_BAD), 1'b0, 1'b0, 1'b0, '0);
    idle(2);
    chk("t6_below_irq", 64'(ifs.irq), 64'd0);
    step(N'(1 << CH_TX_FIFO_BAD), 1'b0, 1'b0, 1'b0, '0);
    chk("t6_irq_reach", 64'(ifs.irq), 64'd0);
    idle(1);
    chk("t6_irq_set_sat", 64'(ifs.irq), 64'd1);
    chk("t6_irq_set_wrap", 64'(ifw.irq), 64'd1);
    step('0, 1'b1, 1'b1, 1'b0, '0);
    chk("t6_irq_clr", 64'(ifs.irq), 64'd0);
    idle(2);
    chk("t6_irq_stays_clr", 64'(ifs.irq | ifw.irq), 64'd0);
`else
    repeat (5) step(N'(1 << CH_TX_FIFO_BAD), 1'b0, 1'b0, 1'b0, '0);
    chk("irq_tied", 64'(ifs.irq | ifw.irq), 64'd0);
`endif

    idle(3);
    chk("sb_drain_sat", 64'(q_s.size()), 64'd0);
    chk("sb_drain_wrap", 64'(q_w.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
